// File: rtl/track_history_pkg.sv
// Shared constants and FSM encoding for the prompt-correlator history stage.
package track_history_pkg;

  localparam int unsigned NumChannels  = 4;
  localparam int unsigned AccWidth     = 20;
  localparam int unsigned ChW          = $clog2(NumChannels);
  localparam int unsigned I2q2Width    = 2 * AccWidth;
  localparam int unsigned DropCntWidth = 8;

  typedef enum logic [2:0] {
    StIdle,
    StSquare,
    StSqrt,
    StWrite,
    StIssue,
    StWait
  } track_state_e;

endpackage

// File: rtl/track_isqrt.sv
// Restoring bit-serial integer square root: root_o = floor(sqrt(radicand_i)), one bit per cycle.
// done_o is high during the final iteration; root_o holds the result from the next cycle on.
module track_isqrt #(
  parameter int unsigned Width = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [2*Width-1:0] radicand_i,
  output logic [Width-1:0]   root_o,
  output logic               done_o
);

  localparam int unsigned CntW = $clog2(Width);

  logic [2*Width-1:0] rad_q;
  logic [Width-1:0]   rem_q;
  logic [Width-1:0]   root_q;
  logic [CntW-1:0]    cnt_q;
  logic               active_q;

  logic [Width+1:0] rem_sh;
  logic [Width+1:0] trial;
  logic [Width-1:0] diff;
  logic             fits;

  // Partial remainder stays below 2^Width until the final step, whose remainder is discarded.
  always_comb begin
    rem_sh = {rem_q, rad_q[2*Width-1 -: 2]};
    trial  = {root_q, 2'b01};
    fits   = (rem_sh >= trial);
    diff   = rem_sh[Width-1:0] - trial[Width-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rad_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start_i) begin
      rad_q    <= radicand_i;
      rem_q    <= '0;
      root_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      rad_q  <= {rad_q[2*Width-3:0], 2'b00};
      rem_q  <= fits ? diff : rem_sh[Width-1:0];
      root_q <= {root_q[Width-2:0], fits};
      cnt_q  <= cnt_q + CntW'(1);
      if (cnt_q == CntW'(Width - 1)) begin
        active_q <= 1'b0;
      end
    end
  end

  assign done_o = active_q && (cnt_q == CntW'(Width - 1));
  assign root_o = root_q;

endmodule

// File: rtl/track_history.sv
// Per-channel prompt I/Q/|IQ| history (k, k-1) feeding the FLL via a start/done handshake.
// Build option TRACK_HISTORY_SKIP_FIRST_EN: suppress fll_start when the channel had no valid k.
module track_history
  import track_history_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = NumChannels,
  parameter int unsigned ACC_WIDTH    = AccWidth,
  localparam int unsigned CH_W        = $clog2(NUM_CHANNELS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dump_valid,
  input  logic [CH_W-1:0]         dump_tag,
  input  logic [ACC_WIDTH-1:0]    i_acc,
  input  logic [ACC_WIDTH-1:0]    q_acc,
  input  logic                    chan_clear,
  input  logic [CH_W-1:0]         chan_clear_tag,
  output logic                    busy,
  output logic                    fll_start,
  output logic [CH_W-1:0]         fll_tag,
  output logic [ACC_WIDTH-1:0]    i_prompt_k,
  output logic [ACC_WIDTH-1:0]    q_prompt_k,
  output logic [ACC_WIDTH-1:0]    i_prompt_km1,
  output logic [ACC_WIDTH-1:0]    q_prompt_km1,
  output logic [ACC_WIDTH-1:0]    iq_prompt_k,
  output logic [ACC_WIDTH-1:0]    iq_prompt_km1,
  input  logic                    fll_done,
  output logic [DropCntWidth-1:0] drop_count
);

  localparam int unsigned SqW = 2 * ACC_WIDTH;

  track_state_e            state_q;
  logic [CH_W-1:0]         tag_q;
  logic [ACC_WIDTH-1:0]    cap_i_q, cap_q_q;
  logic [ACC_WIDTH-1:0]    k_i_q [NUM_CHANNELS];
  logic [ACC_WIDTH-1:0]    k_q_q [NUM_CHANNELS];
  logic [ACC_WIDTH-1:0]    k_iq_q [NUM_CHANNELS];
  logic [ACC_WIDTH-1:0]    km1_i_q [NUM_CHANNELS];
  logic [ACC_WIDTH-1:0]    km1_q_q [NUM_CHANNELS];
  logic [ACC_WIDTH-1:0]    km1_iq_q [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] valid_q;

  logic                    busy_q, fll_start_q;
  logic [CH_W-1:0]         fll_tag_q;
  logic [ACC_WIDTH-1:0]    out_i_k_q, out_q_k_q, out_iq_k_q;
  logic [ACC_WIDTH-1:0]    out_i_km1_q, out_q_km1_q, out_iq_km1_q;
  logic [DropCntWidth-1:0] drop_count_q;

  logic signed [SqW-1:0] i_ext, q_ext, i_sq, q_sq;
  logic [SqW-1:0]        mag_sq;
  logic [ACC_WIDTH-1:0]  root;
  logic                  sqrt_done;
  logic                  clr_hit;
  logic [ACC_WIDTH-1:0]  prev_i, prev_q, prev_iq;
`ifdef TRACK_HISTORY_SKIP_FIRST_EN
  logic                  prev_valid;
`endif

  always_comb begin
    i_ext  = {{ACC_WIDTH{cap_i_q[ACC_WIDTH-1]}}, cap_i_q};
    q_ext  = {{ACC_WIDTH{cap_q_q[ACC_WIDTH-1]}}, cap_q_q};
    i_sq   = i_ext * i_ext;
    q_sq   = q_ext * q_ext;
    mag_sq = i_sq + q_sq;
  end

  // A clear landing in the WRITE cycle must still zero the k-1 being written.
  always_comb begin
    clr_hit = chan_clear && (chan_clear_tag == tag_q);
    prev_i  = clr_hit ? '0 : k_i_q[tag_q];
    prev_q  = clr_hit ? '0 : k_q_q[tag_q];
    prev_iq = clr_hit ? '0 : k_iq_q[tag_q];
`ifdef TRACK_HISTORY_SKIP_FIRST_EN
    prev_valid = valid_q[tag_q] && !clr_hit;
`endif
  end

  track_isqrt #(
    .Width (ACC_WIDTH)
  ) u_isqrt (
    .clk        (clk),
    .reset      (reset),
    .start_i    (state_q == StSquare),
    .radicand_i (mag_sq),
    .root_o     (root),
    .done_o     (sqrt_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      tag_q        <= '0;
      cap_i_q      <= '0;
      cap_q_q      <= '0;
      valid_q      <= '0;
      busy_q       <= 1'b0;
      fll_start_q  <= 1'b0;
      fll_tag_q    <= '0;
      out_i_k_q    <= '0;
      out_q_k_q    <= '0;
      out_iq_k_q   <= '0;
      out_i_km1_q  <= '0;
      out_q_km1_q  <= '0;
      out_iq_km1_q <= '0;
      drop_count_q <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        k_i_q[c]    <= '0;
        k_q_q[c]    <= '0;
        k_iq_q[c]   <= '0;
        km1_i_q[c]  <= '0;
        km1_q_q[c]  <= '0;
        km1_iq_q[c] <= '0;
      end
    end else begin
      if (dump_valid && (state_q != StIdle) && (drop_count_q != '1)) begin
        drop_count_q <= drop_count_q + DropCntWidth'(1);
      end
      if (chan_clear) begin
        valid_q[chan_clear_tag]  <= 1'b0;
        k_i_q[chan_clear_tag]    <= '0;
        k_q_q[chan_clear_tag]    <= '0;
        k_iq_q[chan_clear_tag]   <= '0;
        km1_i_q[chan_clear_tag]  <= '0;
        km1_q_q[chan_clear_tag]  <= '0;
        km1_iq_q[chan_clear_tag] <= '0;
      end
      unique case (state_q)
        StIdle: begin
          if (dump_valid) begin
            tag_q   <= dump_tag;
            cap_i_q <= i_acc;
            cap_q_q <= q_acc;
            busy_q  <= 1'b1;
            state_q <= StSquare;
          end
        end
        StSquare: state_q <= StSqrt;
        StSqrt: begin
          if (sqrt_done) begin
            state_q <= StWrite;
          end
        end
        StWrite: begin
          km1_i_q[tag_q]  <= prev_i;
          km1_q_q[tag_q]  <= prev_q;
          km1_iq_q[tag_q] <= prev_iq;
          k_i_q[tag_q]    <= cap_i_q;
          k_q_q[tag_q]    <= cap_q_q;
          k_iq_q[tag_q]   <= root;
          valid_q[tag_q]  <= 1'b1;
          fll_tag_q       <= tag_q;
          out_i_k_q       <= cap_i_q;
          out_q_k_q       <= cap_q_q;
          out_iq_k_q      <= root;
          out_i_km1_q     <= prev_i;
          out_q_km1_q     <= prev_q;
          out_iq_km1_q    <= prev_iq;
`ifdef TRACK_HISTORY_SKIP_FIRST_EN
          if (prev_valid) begin
            fll_start_q <= 1'b1;
            state_q     <= StIssue;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
`else
          fll_start_q <= 1'b1;
          state_q     <= StIssue;
`endif
        end
        StIssue: begin
          fll_start_q <= 1'b0;
          state_q     <= StWait;
        end
        StWait: begin
          if (fll_done) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy          = busy_q;
  assign fll_start     = fll_start_q;
  assign fll_tag       = fll_tag_q;
  assign i_prompt_k    = out_i_k_q;
  assign q_prompt_k    = out_q_k_q;
  assign iq_prompt_k   = out_iq_k_q;
  assign i_prompt_km1  = out_i_km1_q;
  assign q_prompt_km1  = out_q_km1_q;
  assign iq_prompt_km1 = out_iq_km1_q;
  assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_track_history.sv
// Scoreboard bench for track_history: stimulus pushes expected FLL operands, a monitor pops on fll_start.
module tb_track_history;

  localparam int W = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          dump_valid;
  logic [1:0]    dump_tag;
  logic [W-1:0]  i_acc, q_acc;
  logic          chan_clear;
  logic [1:0]    chan_clear_tag;
  logic          busy, fll_start, fll_done;
  logic [1:0]    fll_tag;
  logic [W-1:0]  i_prompt_k, q_prompt_k, i_prompt_km1, q_prompt_km1;
  logic [W-1:0]  iq_prompt_k, iq_prompt_km1;
  logic [7:0]    drop_count;

  always #5 clk = ~clk;

  track_history dut (
    .clk            (clk),
    .reset          (reset),
    .dump_valid     (dump_valid),
    .dump_tag       (dump_tag),
    .i_acc          (i_acc),
    .q_acc          (q_acc),
    .chan_clear     (chan_clear),
    .chan_clear_tag (chan_clear_tag),
    .busy           (busy),
    .fll_start      (fll_start),
    .fll_tag        (fll_tag),
    .i_prompt_k     (i_prompt_k),
    .q_prompt_k     (q_prompt_k),
    .i_prompt_km1   (i_prompt_km1),
    .q_prompt_km1   (q_prompt_km1),
    .iq_prompt_k    (iq_prompt_k),
    .iq_prompt_km1  (iq_prompt_km1),
    .fll_done       (fll_done),
    .drop_count     (drop_count)
  );

  typedef struct {
    logic [1:0]   tag;
    logic [W-1:0] ik, qk, iqk, ikm1, qkm1, iqkm1;
    int           start_cyc;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           starts = 0;
  int           done_delay = 3;
  logic [W-1:0] m_i[4], m_q[4], m_iq[4];
  bit           m_v[4];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endfunction

  function automatic void model_clear(input logic [1:0] t);
    m_i[t] = '0; m_q[t] = '0; m_iq[t] = '0; m_v[t] = 1'b0;
  endfunction

  // FLL model: compare operands on fll_start, check they hold, then acknowledge.
  initial begin
    exp_t e;
    logic [6*W+1:0] snap;
    bit moved;
    fll_done = 1'b0;
    forever begin
      @(negedge clk);
      if (fll_start === 1'b1) begin
        starts++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: fll_start tag %0d at cycle %0d, none expected",
                   fll_tag, cyc);
        end else begin
          e = exp_q.pop_front();
          check("start_cycle", cyc, e.start_cyc);
          check("fll_tag", fll_tag, e.tag);
          check("i_prompt_k", i_prompt_k, e.ik);
          check("q_prompt_k", q_prompt_k, e.qk);
          check("iq_prompt_k", iq_prompt_k, e.iqk);
          check("i_prompt_km1", i_prompt_km1, e.ikm1);
          check("q_prompt_km1", q_prompt_km1, e.qkm1);
          check("iq_prompt_km1", iq_prompt_km1, e.iqkm1);
        end
        snap = {fll_tag, i_prompt_k, q_prompt_k, iq_prompt_k,
                i_prompt_km1, q_prompt_km1, iq_prompt_km1};
        @(negedge clk);
        check("start_pulse_width", fll_start, 0);
        moved = 1'b0;
        repeat (done_delay) begin
          if ({fll_tag, i_prompt_k, q_prompt_k, iq_prompt_k,
               i_prompt_km1, q_prompt_km1, iq_prompt_km1} !== snap) moved = 1'b1;
          @(negedge clk);
        end
        check("outputs_held", moved, 0);
        fll_done = 1'b1;
        @(negedge clk);
        fll_done = 1'b0;
        check("busy_release", busy, 0);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%0b still high after %0d cycles", busy, n);
    end
  endtask

  // clr: 0 none, 1 clear in the dump cycle, 2 clear while the root is being computed.
  task automatic do_dump(input logic [1:0] t, input logic [W-1:0] i, input logic [W-1:0] q,
                         input logic [W-1:0] iq, input int clr, input bit hold);
    exp_t e;
    bit issue;
    wait_idle();
    if (clr != 0) model_clear(t);
    e.tag = t; e.ik = i; e.qk = q; e.iqk = iq;
    e.ikm1 = m_i[t]; e.qkm1 = m_q[t]; e.iqkm1 = m_iq[t];
    e.start_cyc = cyc + W + 3;
    issue = 1'b1;
`ifdef TRACK_HISTORY_SKIP_FIRST_EN
    issue = m_v[t];
`endif
    if (issue) exp_q.push_back(e);
    m_i[t] = i; m_q[t] = q; m_iq[t] = iq; m_v[t] = 1'b1;
    dump_tag = t; i_acc = i; q_acc = q; dump_valid = 1'b1;
    if (clr == 1) begin
      chan_clear_tag = t;
      chan_clear = 1'b1;
    end
    @(negedge clk);
    dump_valid = 1'b0;
    chan_clear = 1'b0;
    if (clr == 2) begin
      repeat (5) @(negedge clk);
      chan_clear_tag = t;
      chan_clear = 1'b1;
      @(negedge clk);
      chan_clear = 1'b0;
    end
    if (!hold) wait_idle();
  endtask

  initial begin
    int s0;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    reset = 1'b1; dump_valid = 1'b0; dump_tag = '0; i_acc = '0; q_acc = '0;
    chan_clear = 1'b0; chan_clear_tag = '0;
    for (int c = 0; c < 4; c++) model_clear(2'(c));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_fll_start", fll_start, 0);
    check("rst_iq_k", iq_prompt_k, 0);
    check("rst_i_km1", i_prompt_km1, 0);
    check("rst_drop", drop_count, 0);

    do_dump(2'd0, 20'sd3, 20'sd4, 20'd5, 0, 0);
    do_dump(2'd0, -20'sd6, 20'sd8, 20'd10, 0, 0);
    do_dump(2'd1, 20'h80000, 20'sd0, 20'd524288, 0, 0);
    // floor(524287 * sqrt(2)) = floor(741453.79)
    do_dump(2'd1, 20'sd524287, 20'sd524287, 20'd741453, 0, 0);
    do_dump(2'd3, 20'sd100, -20'sd7, 20'd100, 0, 0);
    do_dump(2'd3, 20'sd1, 20'sd1, 20'd1, 0, 0);

    // Drops during a long FLL hold; dropped dumps target ch2 and must not touch it.
    done_delay = 400;
    do_dump(2'd0, 20'sd8, 20'sd15, 20'd17, 0, 1);
    @(negedge clk);
    dump_tag = 2'd2; i_acc = 20'sd100; q_acc = 20'sd100; dump_valid = 1'b1;
    @(negedge clk);
    dump_valid = 1'b0;
    check("drop_one", drop_count, 1);
    dump_valid = 1'b1;
    repeat (300) @(negedge clk);
    dump_valid = 1'b0;
    check("drop_saturate", drop_count, 255);
    wait_idle();
    done_delay = 3;
    do_dump(2'd2, 20'sd5, 20'sd12, 20'd13, 0, 0);

    // Clear ch1 while idle, then dump it.
    chan_clear_tag = 2'd1; chan_clear = 1'b1;
    @(negedge clk);
    chan_clear = 1'b0;
    model_clear(2'd1);
    do_dump(2'd1, -20'sd20, -20'sd21, 20'd29, 0, 0);

    do_dump(2'd0, 20'sd7, 20'sd24, 20'd25, 1, 0);
    do_dump(2'd0, 20'sd9, 20'sd40, 20'd41, 2, 0);
    do_dump(2'd0, -20'sd1, 20'sd0, 20'd1, 0, 0);

    // Reset while the root is being computed.
    wait_idle();
    s0 = starts;
    dump_tag = 2'd3; i_acc = 20'sd2; q_acc = 20'sd2; dump_valid = 1'b1;
    @(negedge clk);
    dump_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_i_k", i_prompt_k, 0);
    check("midrst_iq_km1", iq_prompt_km1, 0);
    check("midrst_drop", drop_count, 0);
    repeat (40) @(negedge clk);
    check("midrst_no_start", starts, s0);
    for (int c = 0; c < 4; c++) model_clear(2'(c));
    do_dump(2'd0, 20'sd3, 20'sd4, 20'd5, 0, 0);
    do_dump(2'd0, 20'sd6, -20'sd8, 20'd10, 0, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
